// File: rtl/firewall_top.sv
// rtl/firewall_top.sv - bus-monitoring firewall: address rules, data signatures, repeat detection, timed lockout
module firewall_top #(
  parameter int          LOCK_CYCLES   = 16,
  parameter int          REPEAT_THRESH = 3,
  parameter logic [15:0] FORBID_ADDR0  = 16'h1234,
  parameter logic [15:0] FORBID_ADDR1  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [15:0] addr,
  input  logic        wr_en,
  input  logic        rd_en,
  output logic        alert_out,
  output logic        firewall_block,
  output logic [1:0]  led_status
);

  localparam logic [4:0] LOCK_LOAD = 5'(LOCK_CYCLES);
  localparam logic [2:0] REP_LIMIT = 3'(REPEAT_THRESH);

  logic        access;
  logic        rule_hit;
  logic        sig_hit;
  logic        rep_hit;
  logic        same_data;
  logic        violation;
  logic [2:0]  rep_next;

  logic        rule_violation;
  logic        signature_flag;
  logic        repeat_flag;
  logic [31:0] last_data;
  logic        hist_valid;
  logic [2:0]  rep_cnt;
  logic [4:0]  lock_cnt;

  assign access    = wr_en | rd_en;
  assign rule_hit  = wr_en & ((addr == FORBID_ADDR0) | (addr == FORBID_ADDR1) | rd_en);
  assign sig_hit   = access & ((data_in == 32'hDEADBEEF) |
                               (data_in == 32'hCAFEBABE) |
                               (data_in == 32'h0000BEEF));
  assign same_data = access & hist_valid & (data_in == last_data);

  // Run length of identical data including the current access, saturating at 7.
  always_comb begin
    rep_next = 3'd1;
    if (same_data) begin
      rep_next = (rep_cnt == 3'd7) ? 3'd7 : rep_cnt + 3'd1;
    end
  end

  assign rep_hit   = access & (rep_next >= REP_LIMIT);
  assign violation = rule_hit | sig_hit | rep_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rule_violation <= 1'b0;
      signature_flag <= 1'b0;
      repeat_flag    <= 1'b0;
      last_data      <= 32'h0;
      hist_valid     <= 1'b0;
      rep_cnt        <= 3'd0;
      lock_cnt       <= 5'd0;
    end else begin
      rule_violation <= rule_hit;
      signature_flag <= sig_hit;
      repeat_flag    <= rep_hit;
      if (access) begin
        last_data  <= data_in;
        hist_valid <= 1'b1;
        rep_cnt    <= rep_next;
      end
      // Every violation restarts the full lockout window.
      if (violation) begin
        lock_cnt <= LOCK_LOAD;
      end else if (lock_cnt != 5'd0) begin
        lock_cnt <= lock_cnt - 5'd1;
      end
    end
  end

  assign alert_out      = rule_violation | signature_flag | repeat_flag;
  assign firewall_block = (lock_cnt != 5'd0);
  assign led_status     = {firewall_block, alert_out};

endmodule

// File: tb/tb_firewall_top.sv
// tb/tb_firewall_top.sv - directed self-checking bench for firewall_top
module tb_firewall_top;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [15:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic        alert_out;
  logic        firewall_block;
  logic [1:0]  led_status;

  int n_cmp;
  int n_bad;

  firewall_top dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .addr           (addr),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .alert_out      (alert_out),
    .firewall_block (firewall_block),
    .led_status     (led_status)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one cycle of stimulus at the falling edge; results are sampled just after the rising edge.
  task automatic cyc(input logic wr, input logic rd, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = wr;
    rd_en   = rd;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag, input int n, input int block_cycles);
    for (int k = 1; k <= n; k++) begin
      cyc(1'b0, 1'b0, 16'h0, 32'h0);
      check(tag, {31'b0, firewall_block}, {31'b0, (k < block_cycles)});
      check({tag, "_alert"}, {31'b0, alert_out}, 32'd0);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    addr    = 16'h0;
    data_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alert", {31'b0, alert_out}, 32'd0);
    check("rst_block", {31'b0, firewall_block}, 32'd0);
    check("rst_led", {30'b0, led_status}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: legal read
    cyc(1'b0, 1'b1, 16'h1000, 32'h12345678);
    check("t1_alert", {31'b0, alert_out}, 32'd0);
    check("t1_block", {31'b0, firewall_block}, 32'd0);
    check("t1_led", {30'b0, led_status}, 32'd0);

    // 2: write to protected address
    cyc(1'b1, 1'b0, 16'h1234, 32'h00000001);
    check("t2_alert", {31'b0, alert_out}, 32'd1);
    check("t2_led", {30'b0, led_status}, 32'd3);
    cyc(1'b0, 1'b0, 16'h0, 32'h0);
    check("t2_led_after", {30'b0, led_status}, 32'd2);
    idle_check("t2_block", 15, 15);
    check("t2_led_end", {30'b0, led_status}, 32'd0);

    // 3: two signatures back to back, lockout counted from the second
    cyc(1'b0, 1'b1, 16'h2000, 32'hCAFEBABE);
    check("t3_sig1", {31'b0, alert_out}, 32'd1);
    cyc(1'b0, 1'b1, 16'h2000, 32'h0000BEEF);
    check("t3_sig2", {31'b0, alert_out}, 32'd1);
    idle_check("t3_block", 16, 16);

    // 4: repeat detection threshold
    cyc(1'b0, 1'b1, 16'h3000, 32'h11111111);
    check("t4_r1", {31'b0, alert_out}, 32'd0);
    cyc(1'b0, 1'b1, 16'h3000, 32'h11111111);
    check("t4_r2", {31'b0, alert_out}, 32'd0);
    cyc(1'b0, 1'b1, 16'h3000, 32'hAAAA5555);
    check("t4_a1", {31'b0, alert_out}, 32'd0);
    cyc(1'b0, 1'b1, 16'h3000, 32'hAAAA5555);
    check("t4_a2", {31'b0, alert_out}, 32'd0);
    cyc(1'b0, 1'b1, 16'h3000, 32'hAAAA5555);
    check("t4_a3", {31'b0, alert_out}, 32'd1);
    check("t4_block", {31'b0, firewall_block}, 32'd1);
    idle_check("t4_idle", 16, 16);

    // read of a protected address is legal; simultaneous strobes are not
    cyc(1'b0, 1'b1, 16'h1234, 32'h00000077);
    check("rd_prot", {31'b0, alert_out}, 32'd0);
    cyc(1'b1, 1'b1, 16'h4000, 32'h00000078);
    check("wr_rd", {31'b0, alert_out}, 32'd1);
    idle_check("wr_rd_idle", 16, 16);

    // 5: rule + signature (+ repeat on third), then lockout expiry
    cyc(1'b1, 1'b0, 16'h0000, 32'hDEADBEEF);
    check("t5_w1", {31'b0, alert_out}, 32'd1);
    cyc(1'b1, 1'b0, 16'h0000, 32'hDEADBEEF);
    check("t5_w2", {31'b0, alert_out}, 32'd1);
    cyc(1'b1, 1'b0, 16'h1234, 32'hDEADBEEF);
    check("t5_w3", {31'b0, alert_out}, 32'd1);
    check("t5_led", {30'b0, led_status}, 32'd3);
    idle_check("t5_idle", 20, 16);

    // 6: reset mid-lockout clears outputs and repeat history
    cyc(1'b0, 1'b1, 16'h3000, 32'h11111111);
    cyc(1'b1, 1'b0, 16'h1234, 32'h11111111);
    check("t6_pre_block", {31'b0, firewall_block}, 32'd1);
    cyc(1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_block", {31'b0, firewall_block}, 32'd0);
    check("t6_rst_led", {30'b0, led_status}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 16'h3000, 32'h11111111);
    check("t6_alert", {31'b0, alert_out}, 32'd0);
    check("t6_block", {31'b0, firewall_block}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/firewall_top.md
Name: firewall_top

Overview:
Bus-monitoring security firewall that sits beside a 16-bit-address / 32-bit-data access port. Each cycle it checks the presented access against three things:
- fixed address rules,
- known-bad data signatures,
- repeated-payload behaviour.
On any violation it raises a one-cycle alert and asserts a timed lockout (block) output. A 2-bit status output drives board LEDs. Internally it is a rule checker, a pattern detector (signature + repeat history) and a lockout timer.

Parameters:
LOCK_CYCLES, 16, cycles firewall_block stays high after the most recent violation (16 = 320 ns at 50 MHz).
REPEAT_THRESH, 3, number of consecutive identical-data accesses that flags a repeat violation (range 2..7).
FORBID_ADDR0, 16'h1234, write-protected address.
FORBID_ADDR1, 16'h0000, write-protected address.

Ports:
- clk  input  1  system clock (50 MHz nominal); all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  32  access data word.
- addr  input  16  access address.
- wr_en  input  1  write strobe.
- rd_en  input  1  read strobe.
- alert_out  output  1  high for each cycle whose sampled access violated any rule.
- firewall_block  output  1  lockout active.
- led_status  output  2  {firewall_block, alert_out}.

Behaviour:
Access definition
- A cycle is an access when wr_en | rd_en. Non-access cycles never violate and do not change repeat history.

Rule checker (rule_violation)
- Set when wr_en=1 and addr equals FORBID_ADDR0 or FORBID_ADDR1.
- Also set when wr_en=1 and rd_en=1 together (illegal strobe combination), regardless of address.
- Reads from the forbidden addresses are legal.

Signature detector (signature_flag)
- Set on an access whose data_in equals 32'hDEADBEEF, 32'hCAFEBABE or 32'h0000BEEF.
- Exact 32-bit compare; address is irrelevant.

Repeat detector (repeat_flag)
- State: last_data (32b), hist_valid (1b), rep_cnt (3b, saturating at 7).
- On an access with hist_valid=1 and data_in==last_data: rep_cnt <= rep_cnt+1 (saturating).
- On any other access: rep_cnt <= 1.
- Every access loads last_data <= data_in and hist_valid <= 1.
- repeat_flag is set when the new rep_cnt >= REPEAT_THRESH. It therefore stays set on the 4th, 5th, … identical access.
- pattern_violation = signature_flag | repeat_flag.

Timing
- The three flags are registered at the rising edge that samples the access.
- alert_out = rule_violation | pattern_violation, taken from the registered flags. It is visible immediately after the sampling edge, lasts one cycle per violating access, and has zero-cycle latency relative to that edge.

Lockout timer
- 5-bit down-counter lock_cnt.
- At a sampling edge with any violation: lock_cnt <= LOCK_CYCLES and firewall_block <= 1. A new violation reloads (extends) the timer even if it is already running.
- Otherwise, if lock_cnt>0: lock_cnt decrements.
- firewall_block is registered and equals (lock_cnt != 0). It is high for exactly LOCK_CYCLES cycles after the last violating edge, then drops.
- Accesses are still evaluated while blocked.

Reset
- rst=1 immediately clears all flags, last_data, hist_valid, rep_cnt and lock_cnt.
- All outputs go to 0: alert_out=0, firewall_block=0, led_status=2'b00.
- Reset mid-lockout ends the lockout at once. After reset, the first access is never a repeat.

Simultaneous events
- Rule and pattern violations in the same cycle produce a single alert cycle and a single timer reload.

Test Plan:
1. Reset, then read addr 16'h1000 with data 32'h12345678 -> alert_out=0, firewall_block=0, led_status=2'b00.
2. Write addr 16'h1234 with data 32'h00000001 -> rule_violation=1, alert_out pulses 1 cycle, firewall_block high 16 cycles, led_status 2'b11 then 2'b10, then 2'b00.
3. Reads with data 32'hCAFEBABE, then 32'h0000BEEF, at addr 16'h2000 -> signature_flag=1 on each; alert on both cycles; lockout extended from the second.
4. Two reads of 32'h11111111 at addr 16'h3000 -> no repeat_flag, no alert. Then three reads of 32'hAAAA5555 -> repeat_flag and alert only on the third.
5. Writes of 32'hDEADBEEF to 16'h0000, 16'h0000, then 16'h1234 -> each cycle alerts (rule + signature; repeat also on the third). Idle 20 cycles -> firewall_block drops 16 cycles after the last write.
6. Assert rst during an active lockout -> firewall_block and led_status clear immediately. A subsequent single read of 32'h11111111 -> no alert.
